// File: rtl/seqdet_param.sv
// seqdet_param: parameterised serial pattern detector with overlap control.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   din_valid  din is accepted on a clk edge only while high
//   din        serial data bit (PATTERN[PAT_LEN-1] is the first bit expected)
//   ovl_en     1 = overlapping detection, 0 = restart from empty after a match
//   cnt_clr    synchronous clear of match_cnt (wins over an increment)
//   dout       Mealy match flag, combinational with the final pattern bit
//   dout_reg   dout delayed by one clk edge
//   match_cnt  saturating count of detected matches
//
// The state k is the length of the longest suffix of accepted bits that is a
// proper prefix of PATTERN. The next-state for every (k, din) pair is a
// KMP-style automaton table built at elaboration from PATTERN; on a match the
// same table yields the longest proper border, which is then kept or dropped
// according to ovl_en.
module seqdet_param #(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1101,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din_valid,
  input  logic             din,
  input  logic             ovl_en,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             dout_reg,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned KW = $clog2(PAT_LEN);
  localparam int unsigned TW = PAT_LEN * KW;
  localparam logic [KW-1:0] LAST = KW'(PAT_LEN - 1);

  // Pattern bit j in arrival order (j = 0 is the first bit received).
  function automatic logic pat_at(input int unsigned j);
    return 1'(PATTERN >> (PAT_LEN - 1 - j));
  endfunction

  // Longest suffix of (prefix_k followed by b) that is a proper prefix of
  // PATTERN. For k = PAT_LEN-1 and b = last pattern bit this is the longest
  // proper border of PATTERN, i.e. the overlap restart point.
  function automatic int unsigned fallback(input int unsigned k, input logic b);
    int unsigned res;
    logic        ok;
    logic        sb;
    res = 0;
    for (int unsigned len = 1; len < PAT_LEN; len++) begin
      if (len <= k + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < len; i++) begin
          sb = (k + 1 - len + i == k) ? b : pat_at(k + 1 - len + i);
          if (sb != pat_at(i)) ok = 1'b0;
        end
        if (ok) res = len;
      end
    end
    return res;
  endfunction

  // Packed table: entry k occupies bits [k*KW +: KW].
  function automatic logic [TW-1:0] build_tbl(input logic b);
    logic [TW-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < PAT_LEN; k++) begin
      t = t | (TW'(fallback(k, b)) << (k * KW));
    end
    return t;
  endfunction

  localparam logic [TW-1:0] NXT0 = build_tbl(1'b0);
  localparam logic [TW-1:0] NXT1 = build_tbl(1'b1);

  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;
  logic [KW-1:0] fb0;
  logic [KW-1:0] fb1;
  logic          exp_bit;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      k <= '0;
    end else begin
      k <= k_nxt;
    end
  end

  always_comb begin
    k_nxt   = k;
    dout    = 1'b0;
    fb0     = '0;
    fb1     = '0;
    exp_bit = 1'b0;
    for (int unsigned i = 0; i < PAT_LEN; i++) begin
      if (k == KW'(i)) begin
        fb0     = KW'(NXT0 >> (i * KW));
        fb1     = KW'(NXT1 >> (i * KW));
        exp_bit = pat_at(i);
      end
    end
    if (din_valid) begin
      // k = 0 during reset and PAT_LEN >= 2, so dout stays low while clr is low.
      dout  = (k == LAST) && (din == exp_bit);
      k_nxt = din ? fb1 : fb0;
      if (dout && !ovl_en) k_nxt = '0;
    end
  end

  // dout_reg tracks dout on every edge, valid or not.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dout_reg <= 1'b0;
    end else begin
      dout_reg <= dout;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (dout && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seqdet_param.sv
// Scoreboard bench for seqdet_param: two instances (default parameters, and a
// 5-bit pattern with a 2-bit counter) share one stimulus stream. A history-
// based reference model predicts each cycle's outputs into a queue; a monitor
// pops and compares on every falling edge.
module tb_seqdet_param;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       ovl_en = 1'b1;
  logic       cnt_clr = 1'b0;
  logic       d0, r0, d1, r1;
  logic [7:0] c0;
  logic [1:0] c1;

  always #5 clk = ~clk;

  seqdet_param u0 (
    .clk(clk), .clr(clr), .din_valid(din_valid), .din(din), .ovl_en(ovl_en),
    .cnt_clr(cnt_clr), .dout(d0), .dout_reg(r0), .match_cnt(c0)
  );

  seqdet_param #(.PAT_LEN(5), .PATTERN(5'b11011), .CNT_W(2)) u1 (
    .clk(clk), .clr(clr), .din_valid(din_valid), .din(din), .ovl_en(ovl_en),
    .cnt_clr(cnt_clr), .dout(d1), .dout_reg(r1), .match_cnt(c1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the accepted-bit history (since reset or since a
  // non-overlapping match) kept as a shift register plus its length.
  int          plen [2] = '{4, 5};
  int          pat  [2] = '{'b1101, 'b11011};
  int          cmax [2] = '{255, 3};
  logic [31:0] sh   [2] = '{32'd0, 32'd0};
  int          hl   [2] = '{0, 0};
  int          cnt  [2] = '{0, 0};
  bit          dreg [2] = '{1'b0, 1'b0};

  typedef struct {
    bit d0, r0, d1, r1;
    int c0, c1;
  } exp_t;
  exp_t q[$];

  function automatic bit m_match(input int m, input bit b);
    logic [31:0] w;
    logic [31:0] mask;
    w    = {sh[m][30:0], b};
    mask = (32'd1 << plen[m]) - 32'd1;
    return (hl[m] + 1 >= plen[m]) && ((w & mask) == 32'(pat[m]));
  endfunction

  task automatic model_cycle();
    bit   de [2];
    exp_t e;
    for (int m = 0; m < 2; m++) de[m] = din_valid && m_match(m, din);
    e.d0 = de[0]; e.r0 = dreg[0]; e.c0 = cnt[0];
    e.d1 = de[1]; e.r1 = dreg[1]; e.c1 = cnt[1];
    q.push_back(e);
    for (int m = 0; m < 2; m++) begin
      dreg[m] = de[m];
      if (cnt_clr) cnt[m] = 0;
      else if (de[m] && cnt[m] < cmax[m]) cnt[m]++;
      if (din_valid) begin
        if (de[m] && !ovl_en) begin
          sh[m] = '0;
          hl[m] = 0;
        end else begin
          sh[m] = {sh[m][30:0], din};
          hl[m]++;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      sh[m] = '0; hl[m] = 0; cnt[m] = 0; dreg[m] = 1'b0;
    end
  endtask

  task automatic step(input bit v, input bit b, input bit ov, input bit cc);
    @(negedge clk);
    din_valid = v; din = b; ovl_en = ov; cnt_clr = cc;
    #1 model_cycle();
  endtask

  task automatic run_bits(input logic [31:0] bits, input int n, input bit ov);
    for (int i = 0; i < n; i++) step(1'b1, 1'(bits >> (n - 1 - i)), ov, 1'b0);
  endtask

  // clr is dropped mid-cycle, held across one rising edge with a would-be
  // valid 1 on din, and released before the next falling edge.
  task automatic pulse_clr();
    @(negedge clk);
    din_valid = 1'b0; cnt_clr = 1'b0;
    #1 model_cycle();
    #2 clr = 1'b0; din_valid = 1'b1; din = 1'b1;
    #1;
    chk("rst_dout0", d0, 0); chk("rst_dreg0", r0, 0); chk("rst_cnt0", c0, 0);
    chk("rst_dout1", d1, 0); chk("rst_dreg1", r1, 0); chk("rst_cnt1", c1, 0);
    model_reset();
    #3 clr = 1'b1; din_valid = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one scoreboard entry per cycle, sampled 2 time units after the
  // falling edge once the new inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dout0", d0, e.d0); chk("dout_reg0", r0, e.r0); chk("cnt0", c0, e.c0);
        chk("dout1", d1, e.d1); chk("dout_reg1", r1, e.r1); chk("cnt1", c1, e.c1);
      end
    end
  end

  initial begin
    #2;
    chk("init_dout0", d0, 0); chk("init_dreg0", r0, 0); chk("init_cnt0", c0, 0);
    chk("init_cnt1", c1, 0);
    repeat (2) @(posedge clk);
    #2 clr = 1'b1;

    // Overlapping vs non-overlapping on 1101101.
    pulse_clr(); run_bits(32'b1101101, 7, 1'b1); after_edge(); chk("ovl_cnt", c0, 2);
    pulse_clr(); run_bits(32'b1101101, 7, 1'b0); after_edge(); chk("novl_cnt", c0, 1);

    // Failure-function fallback: 11101 still matches at bit 5.
    pulse_clr(); run_bits(32'b11101, 5, 1'b1); after_edge(); chk("fallback_cnt", c0, 1);

    // Stall with din=0 must not disturb the partial match.
    pulse_clr(); run_bits(32'b110, 3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    din_valid = 1'b1; din = 1'b1;
    #1 chk("stall_dout", d0, 1);
    model_cycle();
    after_edge(); chk("stall_cnt", c0, 1);

    // Reset right after a match drops dout_reg/count; a partial match is lost.
    pulse_clr(); run_bits(32'b1101, 4, 1'b1);
    pulse_clr(); run_bits(32'b110, 3, 1'b1);
    pulse_clr(); run_bits(32'b1, 1, 1'b1); after_edge(); chk("rst_partial_cnt", c0, 0);
    run_bits(32'b101, 3, 1'b1); after_edge(); chk("rst_k1_cnt", c0, 1);

    // 2-bit counter saturation on 11011 with five overlapping matches, then
    // cnt_clr together with a match.
    pulse_clr(); run_bits(32'b11011011011011011, 17, 1'b1); after_edge();
    chk("sat_cnt", c1, 3);
    run_bits(32'b01, 2, 1'b1);
    @(negedge clk);
    din_valid = 1'b1; din = 1'b1; ovl_en = 1'b1; cnt_clr = 1'b1;
    #1 chk("clr_match_dout", d1, 1);
    model_cycle();
    after_edge(); chk("clr_match_cnt", c1, 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulse_clr();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 39) == 0);
      end
    end

    @(negedge clk);
    din_valid = 1'b0; cnt_clr = 1'b0;
    #4;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
